// File: rtl/hazard_pkg.sv
// Shared types for the execute-stage hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_WB    = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_BUSY,
        MC_DONE
    } mc_state_e;

    localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/fwd_sel_unit.sv
// One-operand forwarding select: EX/MEM beats MEM/WB beats register file; x0 never forwarded.
module fwd_sel_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_wren,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_rd_wren,
    output logic [1:0]        sel
);

    // Priority match of the source against the two in-flight writers
    always_comb begin
        sel = FWD_RF;
        if (mem_rd_wren && (mem_rd_addr != '0) && (mem_rd_addr == src_addr)) begin
            sel = FWD_EXMEM;
        end else if (wb_rd_wren && (wb_rd_addr != '0) && (wb_rd_addr == src_addr)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage pipeline controller: operand forwarding, load-use stall,
// taken-branch flush and multi-cycle (div/rem) sequencing.
// Optional perf counters built when HAZARD_PERF_EN is defined.
module ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 8,
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [REG_AW-1:0] i_ex_rs1_addr,
    input  logic [REG_AW-1:0] i_ex_rs2_addr,
    input  logic              i_ex_valid,
    input  logic [REG_AW-1:0] i_ex_rd_addr,
    input  logic              i_ex_rd_wren,
    input  logic              i_ex_is_load,
    input  logic              i_ex_multicycle,
    input  logic [REG_AW-1:0] i_mem_rd_addr,
    input  logic              i_mem_rd_wren,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    input  logic              i_wb_rd_wren,
    input  logic              i_branch_taken,
    output logic [1:0]        o_forward_a_sel,
    output logic [1:0]        o_forward_b_sel,
    output logic              o_stall_fe,
    output logic              o_flush_if,
    output logic              o_flush_id,
    output logic              o_ex_hold,
    output logic              o_mc_done,
    output logic [31:0]       o_stall_cycles,
    output logic [31:0]       o_flush_count
);

    localparam int unsigned CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    mc_state_e        state, state_nxt;
    logic [CNT_W-1:0] mc_cnt, mc_cnt_nxt;
    logic [1:0]       fwd_a, fwd_b;
    logic             load_use;
    logic             stall_c, flush_if_c, flush_id_c, hold_c, done_c;

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src_addr    (i_ex_rs1_addr),
        .mem_rd_addr (i_mem_rd_addr),
        .mem_rd_wren (i_mem_rd_wren),
        .wb_rd_addr  (i_wb_rd_addr),
        .wb_rd_wren  (i_wb_rd_wren),
        .sel         (fwd_a)
    );

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src_addr    (i_ex_rs2_addr),
        .mem_rd_addr (i_mem_rd_addr),
        .mem_rd_wren (i_mem_rd_wren),
        .wb_rd_addr  (i_wb_rd_addr),
        .wb_rd_wren  (i_wb_rd_wren),
        .sel         (fwd_b)
    );

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use = i_ex_valid && i_ex_is_load && i_ex_rd_wren && (i_ex_rd_addr != '0) &&
                   ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                    (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));
    end

    // Multi-cycle state and latency counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= MC_IDLE;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    // Next state plus stall/flush/hold decode
    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        stall_c    = 1'b0;
        flush_if_c = 1'b0;
        flush_id_c = 1'b0;
        hold_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            MC_IDLE: begin
                if (i_branch_taken) begin
                    flush_if_c = 1'b1;
                    flush_id_c = 1'b1;
                end else if (load_use) begin
                    stall_c    = 1'b1;
                    flush_id_c = 1'b1;
                end
                if (i_ex_valid && i_ex_multicycle && !i_branch_taken) begin
                    state_nxt  = MC_BUSY;
                    mc_cnt_nxt = CNT_W'(MC_LAT - 2);
                end
            end
            MC_BUSY: begin
                hold_c  = 1'b1;
                stall_c = 1'b1;
                if (mc_cnt == '0) begin
                    state_nxt = MC_DONE;
                end else begin
                    mc_cnt_nxt = mc_cnt - CNT_W'(1);
                end
            end
            MC_DONE: begin
                done_c = 1'b1;
                if (load_use) begin
                    stall_c    = 1'b1;
                    flush_id_c = 1'b1;
                end
                state_nxt = MC_IDLE;
            end
            default: begin
                state_nxt = MC_IDLE;
            end
        endcase
    end

    // All control outputs forced low while reset is asserted
    always_comb begin
        o_forward_a_sel = i_reset ? FWD_RF : fwd_a;
        o_forward_b_sel = i_reset ? FWD_RF : fwd_b;
        o_stall_fe      = !i_reset && stall_c;
        o_flush_if      = !i_reset && flush_if_c;
        o_flush_id      = !i_reset && flush_id_c;
        o_ex_hold       = !i_reset && hold_c;
        o_mc_done       = !i_reset && done_c;
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt, flush_cnt;

    // Perf counters: stalled-frontend cycles and taken-branch flushes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + PERF_W'(stall_c);
            flush_cnt <= flush_cnt + PERF_W'(flush_if_c);
        end
    end

    assign o_stall_cycles = i_reset ? 32'd0 : stall_cnt;
    assign o_flush_count  = i_reset ? 32'd0 : flush_cnt;
`else
    assign o_stall_cycles = 32'd0;
    assign o_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed cases then randomized traffic
// against a cycles-remaining reference model.
module tb_ex_hazard_ctrl;

    localparam int MC_LAT = 8;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr;
    logic              id_rs1_used, id_rs2_used;
    logic              ex_valid, ex_rd_wren, ex_is_load, ex_multicycle;
    logic [REG_AW-1:0] ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic              mem_rd_wren, wb_rd_wren, branch_taken;
    logic [1:0]        fwd_a, fwd_b;
    logic              stall_fe, flush_if, flush_id, ex_hold, mc_done;
    logic [31:0]       stall_cycles, flush_count;

    int          n_checks = 0;
    int          n_errors = 0;
    int          mc_left = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    int          hold_seen = 0;
    int          done_seen = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.MC_LAT(MC_LAT), .REG_AW(REG_AW)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_id_rs1_addr   (id_rs1_addr),
        .i_id_rs2_addr   (id_rs2_addr),
        .i_id_rs1_used   (id_rs1_used),
        .i_id_rs2_used   (id_rs2_used),
        .i_ex_rs1_addr   (ex_rs1_addr),
        .i_ex_rs2_addr   (ex_rs2_addr),
        .i_ex_valid      (ex_valid),
        .i_ex_rd_addr    (ex_rd_addr),
        .i_ex_rd_wren    (ex_rd_wren),
        .i_ex_is_load    (ex_is_load),
        .i_ex_multicycle (ex_multicycle),
        .i_mem_rd_addr   (mem_rd_addr),
        .i_mem_rd_wren   (mem_rd_wren),
        .i_wb_rd_addr    (wb_rd_addr),
        .i_wb_rd_wren    (wb_rd_wren),
        .i_branch_taken  (branch_taken),
        .o_forward_a_sel (fwd_a),
        .o_forward_b_sel (fwd_b),
        .o_stall_fe      (stall_fe),
        .o_flush_if      (flush_if),
        .o_flush_id      (flush_id),
        .o_ex_hold       (ex_hold),
        .o_mc_done       (mc_done),
        .o_stall_cycles  (stall_cycles),
        .o_flush_count   (flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input int src, input int mrd, input bit mw,
                                           input int wrd, input bit ww);
        if (mw && mrd != 0 && mrd == src) return 2'b10;
        if (ww && wrd != 0 && wrd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rs1_addr = '0; ex_rs2_addr = '0; ex_valid = 1'b0; ex_rd_addr = '0;
        ex_rd_wren = 1'b0; ex_is_load = 1'b0; ex_multicycle = 1'b0;
        mem_rd_addr = '0; mem_rd_wren = 1'b0; wb_rd_addr = '0; wb_rd_wren = 1'b0;
        branch_taken = 1'b0;
    endtask

    // Check all outputs against the model at negedge, then advance the model at posedge
    task automatic cycle();
        bit          lu, busy, idle;
        logic [1:0]  ea, eb;
        logic        es, efi, efd, eh, ed;
        logic [31:0] esc, efc;
        @(negedge clk);
        idle = (mc_left == 0);
        busy = (mc_left > 1);
        lu = ex_valid && ex_is_load && ex_rd_wren && ex_rd_addr != 0 &&
             ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr));
        ea = ref_fwd(int'(ex_rs1_addr), int'(mem_rd_addr), mem_rd_wren, int'(wb_rd_addr), wb_rd_wren);
        eb = ref_fwd(int'(ex_rs2_addr), int'(mem_rd_addr), mem_rd_wren, int'(wb_rd_addr), wb_rd_wren);
        eh = busy;
        ed = (mc_left == 1);
        if (busy) begin
            es = 1'b1; efi = 1'b0; efd = 1'b0;
        end else if (idle && branch_taken) begin
            es = 1'b0; efi = 1'b1; efd = 1'b1;
        end else begin
            es = lu; efi = 1'b0; efd = lu;
        end
`ifdef HAZARD_PERF_EN
        esc = m_stall;
        efc = m_flush;
`else
        esc = 32'd0;
        efc = 32'd0;
`endif
        if (reset) begin
            ea = 2'b00; eb = 2'b00; es = 1'b0; efi = 1'b0; efd = 1'b0;
            eh = 1'b0; ed = 1'b0; esc = 32'd0; efc = 32'd0;
        end
        check("fwd_a", 32'(fwd_a), 32'(ea));
        check("fwd_b", 32'(fwd_b), 32'(eb));
        check("stall_fe", 32'(stall_fe), 32'(es));
        check("flush_if", 32'(flush_if), 32'(efi));
        check("flush_id", 32'(flush_id), 32'(efd));
        check("ex_hold", 32'(ex_hold), 32'(eh));
        check("mc_done", 32'(mc_done), 32'(ed));
        check("stall_cycles", stall_cycles, esc);
        check("flush_count", flush_count, efc);
        hold_seen += int'(ex_hold);
        done_seen += int'(mc_done);
        @(posedge clk);
        if (reset) begin
            mc_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_stall += 32'(es);
            m_flush += 32'(efi);
            if (mc_left > 0) mc_left--;
            else if (ex_valid && ex_multicycle && !branch_taken) mc_left = MC_LAT;
        end
        #1;
    endtask

    task automatic set_load_use(input bit use2);
        clear_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_wren = 1'b1; ex_rd_addr = 5'd7;
        id_rs2_addr = 5'd7; id_rs2_used = use2;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Forwarding priority and x0 exclusion
        mem_rd_addr = 5'd5; mem_rd_wren = 1'b1; wb_rd_addr = 5'd5; wb_rd_wren = 1'b1; ex_rs1_addr = 5'd5;
        #2 check("dir_fwd_exmem", 32'(fwd_a), 32'h2);
        cycle();
        mem_rd_wren = 1'b0;
        #2 check("dir_fwd_wb", 32'(fwd_a), 32'h1);
        cycle();
        clear_inputs();
        mem_rd_wren = 1'b1; ex_rs2_addr = 5'd0;
        #2 check("dir_fwd_x0", 32'(fwd_b), 32'h0);
        cycle();

        // Perf scenario: 3 load-use stalls, 1 flush (load-use + branch together)
        clear_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_load_use(1'b1);
            #2 check("dir_lu_stall", 32'({stall_fe, flush_id}), 32'h3);
            cycle();
            clear_inputs();
            cycle();
        end
        set_load_use(1'b0);
        #2 check("dir_lu_unused", 32'(stall_fe), 32'h0);
        cycle();
        set_load_use(1'b1);
        branch_taken = 1'b1;
        #2 check("dir_br_over_lu", 32'({flush_if, flush_id, stall_fe}), 32'h6);
        cycle();
        clear_inputs();
        #2;
`ifdef HAZARD_PERF_EN
        check("dir_perf_stall", stall_cycles, 32'd3);
        check("dir_perf_flush", flush_count, 32'd1);
`else
        check("dir_perf_stall", stall_cycles, 32'd0);
        check("dir_perf_flush", flush_count, 32'd0);
`endif
        cycle();

        // Full multi-cycle op
        ex_valid = 1'b1; ex_multicycle = 1'b1;
        hold_seen = 0; done_seen = 0;
        cycle();
        clear_inputs();
        for (int i = 0; i < 11; i++) cycle();
        check("dir_mc_hold_cycles", 32'(hold_seen), 32'd7);
        check("dir_mc_done_pulses", 32'(done_seen), 32'd1);

        // Reset in the middle of a multi-cycle op
        ex_valid = 1'b1; ex_multicycle = 1'b1;
        cycle();
        clear_inputs();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        hold_seen = 0; done_seen = 0;
        for (int i = 0; i < 10; i++) cycle();
        check("dir_mc_reset_hold", 32'(hold_seen), 32'd0);
        check("dir_mc_reset_done", 32'(done_seen), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 149) == 0);
            id_rs1_addr   = 5'($urandom_range(0, 7));
            id_rs2_addr   = 5'($urandom_range(0, 7));
            id_rs1_used   = 1'($urandom_range(0, 1));
            id_rs2_used   = 1'($urandom_range(0, 1));
            ex_rs1_addr   = 5'($urandom_range(0, 7));
            ex_rs2_addr   = 5'($urandom_range(0, 7));
            ex_valid      = 1'($urandom_range(0, 3) != 0);
            ex_rd_addr    = 5'($urandom_range(0, 7));
            ex_rd_wren    = 1'($urandom_range(0, 1));
            ex_is_load    = ($urandom_range(0, 2) == 0);
            ex_multicycle = ($urandom_range(0, 9) == 0);
            mem_rd_addr   = 5'($urandom_range(0, 7));
            mem_rd_wren   = 1'($urandom_range(0, 1));
            wb_rd_addr    = 5'($urandom_range(0, 7));
            wb_rd_wren    = 1'($urandom_range(0, 1));
            branch_taken  = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
